// File: rtl/mem_access_unit_if.sv
// Pipeline/memory-side bus of mem_access_unit.
// slave  : view taken by mem_access_unit (accepts requests, drives the memory port).
// master : view taken by the pipeline and the data memory.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_addr;
    logic        memwr;
    logic [31:0] dout;
    logic [31:0] din;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, din,
        output req_ready, resp_valid, resp_rdata, resp_err, data_addr, memwr, dout
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, din,
        input  req_ready, resp_valid, resp_rdata, resp_err, data_addr, memwr, dout
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a big-endian, word-wide data memory.
// One request at a time; byte/halfword stores are done as read-modify-write.
// Optional build macro MEM_ACCESS_PERF_EN adds saturating load/store/error counters.
module mem_access_unit #(
    parameter int unsigned MEMSIZE = 1024
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [15:0]        perf_loads,
    output logic [15:0]        perf_stores,
    output logic [15:0]        perf_errs
`endif
);

    localparam logic [31:0] LAST_WORD = 32'(MEMSIZE - 4);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t      state, state_nx;

    // request fields captured at acceptance
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;
    logic        lat_err;

    // registered outputs
    logic [31:0] addr_q, addr_nx;
    logic        memwr_q, memwr_nx;
    logic [31:0] dout_q, dout_nx;
    logic [31:0] rdata_q, rdata_nx;
    logic        err_q, err_nx;
    logic        capture;

    logic        req_bad;
    logic [4:0]  lane_shift;
    logic [31:0] din_sh;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] merged;

    // request legality: size, alignment and word-address range
    always_comb begin
        req_bad = 1'b0;
        if (bus.req_size == 2'b11)
            req_bad = 1'b1;
        else if (bus.req_size == 2'b01 && bus.req_addr[0])
            req_bad = 1'b1;
        else if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
        if ({bus.req_addr[31:2], 2'b00} > LAST_WORD)
            req_bad = 1'b1;
    end

    // big-endian lane extraction and merge; byte o sits at bit (3-o)*8
    always_comb begin
        lane_shift = {~lat_off, 3'b000};
        din_sh     = bus.din >> lane_shift;
        byte_val   = din_sh[7:0];
        half_val   = lat_off[1] ? bus.din[15:0] : bus.din[31:16];

        case (lat_size)
            2'b00:   load_val = {{24{lat_signed & byte_val[7]}}, byte_val};
            2'b01:   load_val = {{16{lat_signed & half_val[15]}}, half_val};
            default: load_val = bus.din;
        endcase

        if (lat_size == 2'b00)
            merged = (bus.din & ~(32'h0000_00FF << lane_shift))
                   | ({24'h0, lat_wdata[7:0]} << lane_shift);
        else if (lat_off[1])
            merged = {bus.din[31:16], lat_wdata};
        else
            merged = {lat_wdata, bus.din[15:0]};
    end

    // next-state and next values of the registered outputs
    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        memwr_nx = 1'b0;
        dout_nx  = dout_q;
        rdata_nx = rdata_q;
        err_nx   = err_q;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    capture  = 1'b1;
                    rdata_nx = '0;
                    err_nx   = req_bad;
                    if (req_bad) begin
                        state_nx = RESP;
                    end else begin
                        addr_nx = {bus.req_addr[31:2], 2'b00};
                        if (!bus.req_we) begin
                            state_nx = LOAD;
                        end else if (bus.req_size == 2'b10) begin
                            dout_nx  = bus.req_wdata;
                            memwr_nx = 1'b1;
                            state_nx = WRITE;
                        end else begin
                            state_nx = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                rdata_nx = load_val;
                state_nx = RESP;
            end
            RMW_RD: begin
                dout_nx  = merged;
                memwr_nx = 1'b1;
                state_nx = WRITE;
            end
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state and output registers; reset drops memwr at once so no partial write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            memwr_q <= 1'b0;
            dout_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            memwr_q <= memwr_nx;
            dout_q  <= dout_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
        end
    end

    // request field capture at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we     <= 1'b0;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_off    <= '0;
            lat_wdata  <= '0;
            lat_err    <= 1'b0;
        end else if (capture) begin
            lat_we     <= bus.req_we;
            lat_size   <= bus.req_size;
            lat_signed <= bus.req_signed;
            lat_off    <= bus.req_addr[1:0];
            lat_wdata  <= bus.req_wdata[15:0];
            lat_err    <= req_bad;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.data_addr  = addr_q;
    assign bus.memwr      = memwr_q;
    assign bus.dout       = dout_q;

`ifdef MEM_ACCESS_PERF_EN
    // completed-request counters, saturating, classified on the response cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (state == RESP) begin
            if (lat_err) begin
                if (perf_errs != '1) perf_errs <= perf_errs + 16'd1;
            end else if (lat_we) begin
                if (perf_stores != '1) perf_stores <= perf_stores + 16'd1;
            end else begin
                if (perf_loads != '1) perf_loads <= perf_loads + 16'd1;
            end
        end
    end
`endif

endmodule
